// File: rtl/gpio_irq_pio.sv
// rtl/gpio_irq_pio.sv - debounced GPIO inputs with edge-capture IRQ and set/clear output register
module gpio_irq_pio #(
    parameter int                   IN_WIDTH        = 4,
    parameter int                   OUT_WIDTH       = 8,
    parameter int                   DEBOUNCE_CYCLES = 1000,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 ins_irq,
    input  logic [IN_WIDTH-1:0]  coe_in,
    output logic [OUT_WIDTH-1:0] coe_out
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    localparam logic [2:0] A_IN       = 3'd0;
    localparam logic [2:0] A_OUT      = 3'd1;
    localparam logic [2:0] A_OUT_SET  = 3'd2;
    localparam logic [2:0] A_OUT_CLR  = 3'd3;
    localparam logic [2:0] A_IRQ_MASK = 3'd4;
    localparam logic [2:0] A_EDGE_CAP = 3'd5;
    localparam logic [2:0] A_RISE_EN  = 3'd6;
    localparam logic [2:0] A_FALL_EN  = 3'd7;

    logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
    logic [IN_WIDTH-1:0]  deb;
    logic [IN_WIDTH-1:0]  deb_prev_q;
    logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
    logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 irq_q, irq_d;

    logic [IN_WIDTH-1:0]  wd_in;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  rise, fall, w1c;
    logic                 unused_wd;

    assign wd_in     = avs_writedata[IN_WIDTH-1:0];
    assign wd_out    = avs_writedata[OUT_WIDTH-1:0];
    assign unused_wd = ^avs_writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= coe_in;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
            assign deb = sync2_q;
        end else begin : g_deb
            localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0]    cnt_q [IN_WIDTH];
            logic [CNT_W-1:0]    cnt_d [IN_WIDTH];
            logic [IN_WIDTH-1:0] deb_q, deb_d;

            // Any sample that agrees with the accepted state restarts the stability count.
            always_comb begin
                deb_d = deb_q;
                for (int i = 0; i < IN_WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (sync2_q[i] != deb_q[i]) begin
                        if (cnt_q[i] == LAST) deb_d[i] = ~deb_q[i];
                        else                  cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    deb_q <= '0;
                    for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    deb_q <= deb_d;
                    for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    assign rise = deb & ~deb_prev_q;
    assign fall = ~deb & deb_prev_q;
    assign w1c  = (avs_write && avs_address == A_EDGE_CAP) ? wd_in : '0;

    always_comb begin
        out_d      = out_q;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        if (avs_write) begin
            case (avs_address)
                A_OUT:      out_d      = wd_out;
                A_OUT_SET:  out_d      = out_q | wd_out;
                A_OUT_CLR:  out_d      = out_q & ~wd_out;
                A_IRQ_MASK: irq_mask_d = wd_in;
                A_RISE_EN:  rise_en_d  = wd_in;
                A_FALL_EN:  fall_en_d  = wd_in;
                default:    ;
            endcase
        end
        // A new edge beats a same-cycle clear on the same bit.
        edge_cap_d = (edge_cap_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d      = |(edge_cap_q & irq_mask_q);
    end

    always_comb begin
        readdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                A_IN:       readdata_d = 32'(deb);
                A_OUT:      readdata_d = 32'(out_q);
                A_IRQ_MASK: readdata_d = 32'(irq_mask_q);
                A_EDGE_CAP: readdata_d = 32'(edge_cap_q);
                A_RISE_EN:  readdata_d = 32'(rise_en_q);
                A_FALL_EN:  readdata_d = 32'(fall_en_q);
                default:    readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev_q <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            out_q      <= OUT_RESET_VALUE;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign ins_irq      = irq_q;
    assign coe_out      = out_q;

endmodule

// File: tb/tb_gpio_irq_pio.sv
// tb/tb_gpio_irq_pio.sv - scoreboard bench for gpio_irq_pio against a cycle-level reference model
module tb_gpio_irq_pio;
    localparam int         IW  = 4;
    localparam int         OW  = 8;
    localparam int         DC  = 10;
    localparam logic [7:0] ORV = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          ins_irq;
    logic [IW-1:0] coe_in = '0;
    logic [OW-1:0] coe_out;

    gpio_irq_pio #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEBOUNCE_CYCLES(DC), .OUT_RESET_VALUE(ORV)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .ins_irq(ins_irq), .coe_in(coe_in), .coe_out(coe_out)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [31:0] rdata;
        logic        irq;
        logic [7:0]  out;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: register file plus a per-bit rule "the accepted input flips once the
    // last DC synchronised samples all disagree with it".
    logic [7:0]    m_out = ORV;
    logic [IW-1:0] m_mask = '0, m_cap = '0, m_ren = '0, m_fen = '0;
    logic [IW-1:0] m_deb = '0, m_prev = '0;
    logic          m_irq = 1'b0;
    logic [IW-1:0] m_hist[$];

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_deb);
            3'd1:    return 32'(m_out);
            3'd4:    return 32'(m_mask);
            3'd5:    return 32'(m_cap);
            3'd6:    return 32'(m_ren);
            3'd7:    return 32'(m_fen);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [IW-1:0] hist_at(input int k);
        if (k < m_hist.size()) return m_hist[k];
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        exp_t          e;
        logic [IW-1:0] rise, fall, w1c, flip;
        logic [31:0]   wd;
        e = '0;
        if (reset) begin
            m_out = ORV; m_mask = '0; m_cap = '0; m_ren = '0; m_fen = '0;
            m_deb = '0; m_prev = '0; m_irq = 1'b0;
            m_hist.delete();
        end else begin
            wd      = avs_writedata;
            e.rd    = avs_read;
            e.rdata = avs_read ? m_read(avs_address) : 32'd0;
            rise    = m_deb & ~m_prev;
            fall    = ~m_deb & m_prev;
            w1c     = (avs_write && avs_address == 3'd5) ? wd[IW-1:0] : '0;
            m_irq   = |(m_cap & m_mask);
            m_cap   = (m_cap & ~w1c) | (rise & m_ren) | (fall & m_fen);
            if (avs_write) begin
                case (avs_address)
                    3'd1: m_out  = wd[7:0];
                    3'd2: m_out  = m_out | wd[7:0];
                    3'd3: m_out  = m_out & ~wd[7:0];
                    3'd4: m_mask = wd[IW-1:0];
                    3'd6: m_ren  = wd[IW-1:0];
                    3'd7: m_fen  = wd[IW-1:0];
                    default: ;
                endcase
            end
            m_hist.push_front(coe_in);
            if (m_hist.size() > DC + 2) void'(m_hist.pop_back());
            flip = '1;
            for (int k = 2; k <= DC + 1; k++) flip &= (hist_at(k) ^ m_deb);
            m_prev = m_deb;
            m_deb  = m_deb ^ flip;
        end
        e.irq = m_irq;
        e.out = m_out;
        if (clk) sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("coe_out", 32'(coe_out), 32'(e.out));
            chk("ins_irq", 32'(ins_irq), 32'(e.irq));
            if (e.rd) chk("readdata", avs_readdata, e.rdata);
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int a = 0; a < 8; a++) bus(1'b1, 1'b0, 3'(a), 32'd0);
        idle();

        bus(1'b0, 1'b1, 3'd1, 32'h0F);
        bus(1'b0, 1'b1, 3'd2, 32'hF0);
        bus(1'b0, 1'b1, 3'd3, 32'h03);
        bus(1'b1, 1'b0, 3'd2, 32'd0);
        bus(1'b1, 1'b0, 3'd3, 32'd0);
        bus(1'b1, 1'b0, 3'd1, 32'd0);
        bus(1'b0, 1'b1, 3'd2, 32'h00);
        bus(1'b0, 1'b1, 3'd3, 32'h01);
        bus(1'b1, 1'b1, 3'd1, 32'h5A);

        bus(1'b0, 1'b1, 3'd6, 32'h1);
        bus(1'b0, 1'b1, 3'd7, 32'h0);
        bus(1'b0, 1'b1, 3'd4, 32'h1);

        // 9-cycle glitch on bit0 must be rejected.
        idle(); coe_in[0] = 1'b1;
        repeat (8) idle();
        idle(); coe_in[0] = 1'b0;
        repeat (20) bus(1'b1, 1'b0, 3'd0, 32'd0);
        bus(1'b1, 1'b0, 3'd5, 32'd0);

        idle(); coe_in[0] = 1'b1;
        repeat (16) bus(1'b1, 1'b0, 3'd0, 32'd0);
        bus(1'b1, 1'b0, 3'd5, 32'd0);
        repeat (3) idle();

        idle(); coe_in[0] = 1'b0;
        repeat (16) bus(1'b1, 1'b0, 3'd0, 32'd0);
        bus(1'b1, 1'b0, 3'd5, 32'd0);
        bus(1'b0, 1'b1, 3'd5, 32'h1);
        bus(1'b1, 1'b0, 3'd5, 32'd0);
        repeat (2) idle();

        // Clear of bit1 lands on the same edge as its second rising capture.
        bus(1'b0, 1'b1, 3'd6, 32'h3);
        bus(1'b0, 1'b1, 3'd4, 32'h2);
        idle(); coe_in[1] = 1'b1;
        repeat (15) idle();
        idle(); coe_in[1] = 1'b0;
        repeat (15) idle();
        idle(); coe_in[1] = 1'b1;
        repeat (11) idle();
        bus(1'b0, 1'b1, 3'd5, 32'h2);
        bus(1'b1, 1'b0, 3'd5, 32'd0);
        idle();

        // Reset while bit2 is mid-debounce.
        bus(1'b0, 1'b1, 3'd1, 32'h3C);
        bus(1'b1, 1'b0, 3'd1, 32'd0); coe_in[2] = 1'b1;
        repeat (8) idle();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_coe_out", 32'(coe_out), 32'(ORV));
        chk("async_reset_irq", 32'(ins_irq), 32'd0);
        chk("async_reset_readdata", avs_readdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (15) bus(1'b1, 1'b0, 3'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] a;
            int         op;
            a  = 3'($urandom_range(0, 7));
            op = int'($urandom_range(0, 3));
            bus(op == 1 || op == 3, op >= 2, a, $urandom);
            if ($urandom_range(0, 5) == 0) coe_in = coe_in ^ IW'(1 << $urandom_range(0, IW - 1));
        end
        repeat (4) idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
